exc_ctrl: RTL and testbench

Exception/interrupt sequencing controller sitting between the external interrupt sources, the CP0 register block and the pipeline front end. It synchronises and conditions up to six asynchronous interrupt lines into the CP0 `HWInt` vector, and turns CP0's `Req` or an `eret` commit into a clean pipeline flush plus a handshaked PC redirect (handler entry or EPC). It owns the only path that drives CP0 `EXLClr`.

---
 rtl/exc_ctrl_pkg.sv | 16 +
 rtl/exc_ctrl_irq_sync.sv | 36 +++
 rtl/exc_ctrl.sv | 114 +++++++++++
 tb/tb_exc_ctrl.sv | 244 ++++++++++++++++++++++++
 4 files changed

// File: rtl/exc_ctrl_pkg.sv
// Shared types and constants for the exception/interrupt sequencing controller.
package exc_ctrl_pkg;

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        REDIRECT = 2'd1
    } state_t;

    localparam logic [1:0] ADDR_MODE   = 2'd0;
    localparam logic [1:0] ADDR_PEND   = 2'd1;
    localparam logic [1:0] ADDR_RAW    = 2'd2;
    localparam logic [1:0] ADDR_STATUS = 2'd3;

    localparam logic [31:0] HANDLER_PC_DEFAULT = 32'h0000_4180;

endpackage

// File: rtl/exc_ctrl_irq_sync.sv
// One interrupt source: 3-flop synchroniser, rising-edge detect and sticky PEND bit.
module irq_sync (
    input  logic clk,
    input  logic reset,
    input  logic irq,
    input  logic mode,
    input  logic clr,
    output logic raw,
    output logic pend,
    output logic hw_int
);

    logic s1, s2, s3;
    logic edge_set;

    // s3 only exists to give the edge detector a registered previous value
    assign edge_set = mode & s2 & ~s3;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            s1   <= 1'b0;
            s2   <= 1'b0;
            s3   <= 1'b0;
            pend <= 1'b0;
        end else begin
            s1   <= irq;
            s2   <= s1;
            s3   <= s2;
            pend <= edge_set | (pend & ~clr);
        end
    end

    assign raw    = s2;
    assign hw_int = mode ? pend : s2;

endmodule

// File: rtl/exc_ctrl.sv
// Interrupt conditioning into CP0 HWInt, plus flush / EXLClr / PC-redirect sequencing.
module exc_ctrl
    import exc_ctrl_pkg::*;
#(
    parameter int          NSRC       = 6,
    parameter logic [31:0] HANDLER_PC = HANDLER_PC_DEFAULT
) (
    input  logic            clk,
    input  logic            reset,
    input  logic [NSRC-1:0] irq_in,
    input  logic            cfg_we,
    input  logic [1:0]      cfg_addr,
    input  logic [31:0]     cfg_wdata,
    output logic [31:0]     cfg_rdata,
    output logic [5:0]      hw_int,
    input  logic            cp0_req,
    input  logic [31:0]     epc,
    input  logic            eret,
    output logic            flush,
    output logic            exl_clr,
    output logic            redir_valid,
    output logic [31:0]     redir_pc,
    input  logic            redir_ready
);

    logic [NSRC-1:0] mode_q;
    logic [NSRC-1:0] clr;
    logic [NSRC-1:0] raw;
    logic [NSRC-1:0] pend;
    logic [NSRC-1:0] hw_v;
    state_t          state, state_n;
    logic [31:0]     pc_n;
    logic            unused_wdata;

    assign unused_wdata = ^cfg_wdata;

    assign clr = (cfg_we && cfg_addr == ADDR_PEND) ? cfg_wdata[NSRC-1:0] : '0;

    for (genvar g = 0; g < NSRC; g++) begin : g_src
        irq_sync u_sync (
            .clk    (clk),
            .reset  (reset),
            .irq    (irq_in[g]),
            .mode   (mode_q[g]),
            .clr    (clr[g]),
            .raw    (raw[g]),
            .pend   (pend[g]),
            .hw_int (hw_v[g])
        );
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            mode_q <= '0;
        end else if (cfg_we && cfg_addr == ADDR_MODE) begin
            mode_q <= cfg_wdata[NSRC-1:0];
        end
    end

    always_comb begin
        hw_int           = '0;
        hw_int[NSRC-1:0] = hw_v;
    end

    always_comb begin
        cfg_rdata = '0;
        case (cfg_addr)
            ADDR_MODE:   cfg_rdata[NSRC-1:0] = mode_q;
            ADDR_PEND:   cfg_rdata[NSRC-1:0] = pend;
            ADDR_RAW:    cfg_rdata[NSRC-1:0] = raw;
            ADDR_STATUS: cfg_rdata[1:0]      = state;
            default:     cfg_rdata           = '0;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state    <= IDLE;
            redir_pc <= '0;
        end else begin
            state    <= state_n;
            redir_pc <= pc_n;
        end
    end

    // reset gating keeps flush/exl_clr quiet while the block is held in reset
    always_comb begin
        state_n = state;
        pc_n    = redir_pc;
        flush   = 1'b0;
        exl_clr = 1'b0;
        case (state)
            IDLE: begin
                if (reset && cp0_req) begin
                    flush   = 1'b1;
                    pc_n    = HANDLER_PC;
                    state_n = REDIRECT;
                end else if (reset && eret) begin
                    flush   = 1'b1;
                    exl_clr = 1'b1;
                    pc_n    = epc;
                    state_n = REDIRECT;
                end
            end
            REDIRECT: begin
                if (redir_ready) state_n = IDLE;
            end
            default: state_n = IDLE;
        endcase
    end

    assign redir_valid = (state == REDIRECT);

endmodule

// File: tb/tb_exc_ctrl.sv
// Directed and randomized checks of exc_ctrl against a sample-history reference model.
module tb_exc_ctrl;
    import exc_ctrl_pkg::*;

    logic        clk = 1'b0;
    logic        reset;
    logic [5:0]  irq_in;
    logic        cfg_we;
    logic [1:0]  cfg_addr;
    logic [31:0] cfg_wdata;
    logic [31:0] cfg_rdata;
    logic [5:0]  hw_int;
    logic        cp0_req;
    logic [31:0] epc;
    logic        eret;
    logic        flush;
    logic        exl_clr;
    logic        redir_valid;
    logic [31:0] redir_pc;
    logic        redir_ready;

    int checks = 0;
    int errors = 0;

    // reference model: MODE/PEND images, history of irq_in samples (index 0 = newest),
    // and whether a redirect is outstanding
    logic [5:0]  m_mode, m_pend;
    logic [5:0]  hist[$];
    bit          m_busy;
    logic [31:0] m_pc;

    exc_ctrl #(.NSRC(6), .HANDLER_PC(32'h0000_4180)) dut (
        .clk         (clk),
        .reset       (reset),
        .irq_in      (irq_in),
        .cfg_we      (cfg_we),
        .cfg_addr    (cfg_addr),
        .cfg_wdata   (cfg_wdata),
        .cfg_rdata   (cfg_rdata),
        .hw_int      (hw_int),
        .cp0_req     (cp0_req),
        .epc         (epc),
        .eret        (eret),
        .flush       (flush),
        .exl_clr     (exl_clr),
        .redir_valid (redir_valid),
        .redir_pc    (redir_pc),
        .redir_ready (redir_ready)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_mode = '0;
        m_pend = '0;
        m_busy = 0;
        m_pc   = '0;
        hist.delete();
        repeat (4) hist.push_back(6'h00);
    endtask

    // apply one rising edge to the model using the inputs present at that edge
    task automatic model_edge();
        logic [5:0] eset, w1c;
        if (reset) begin
            eset   = m_mode & hist[1] & ~hist[2];
            w1c    = (cfg_we && cfg_addr == 2'd1) ? cfg_wdata[5:0] : 6'h00;
            m_pend = eset | (m_pend & ~w1c);
            if (cfg_we && cfg_addr == 2'd0) m_mode = cfg_wdata[5:0];
            hist.push_front(irq_in);
            void'(hist.pop_back());
            if (!m_busy) begin
                if (cp0_req) begin
                    m_busy = 1;
                    m_pc   = 32'h0000_4180;
                end else if (eret) begin
                    m_busy = 1;
                    m_pc   = epc;
                end
            end else if (redir_ready) begin
                m_busy = 0;
            end
        end
    endtask

    task automatic check_all(input string tag);
        logic [31:0] exp_rd;
        logic        trig;
        case (cfg_addr)
            2'd0:    exp_rd = {26'b0, m_mode};
            2'd1:    exp_rd = {26'b0, m_pend};
            2'd2:    exp_rd = {26'b0, hist[1]};
            default: exp_rd = {31'b0, m_busy};
        endcase
        trig = reset && !m_busy;
        chk({tag, ".hw_int"},  {26'b0, hw_int}, {26'b0, (m_mode & m_pend) | (~m_mode & hist[1])});
        chk({tag, ".flush"},   {31'b0, flush},   {31'b0, trig && (cp0_req || eret)});
        chk({tag, ".exl_clr"}, {31'b0, exl_clr}, {31'b0, trig && eret && !cp0_req});
        chk({tag, ".rvalid"},  {31'b0, redir_valid}, {31'b0, m_busy});
        chk({tag, ".rpc"},     redir_pc, m_pc);
        chk({tag, ".rdata"},   cfg_rdata, exp_rd);
    endtask

    task automatic cycle(input string tag);
        #1;
        check_all(tag);
        @(posedge clk);
        model_edge();
        #1;
    endtask

    initial begin
        reset = 1'b0; irq_in = 6'h3F; cfg_we = 0; cfg_addr = 2'd0; cfg_wdata = '0;
        cp0_req = 0; epc = '0; eret = 0; redir_ready = 0;
        model_reset();

        // reset state with all sources asserted
        #3;
        check_all("rst");
        chk("rst.hw_zero", {26'b0, hw_int}, 32'h0);
        @(posedge clk);
        #1 reset = 1'b1;
        cycle("lvl");
        cycle("lvl");
        chk("lvl.hw_3f", {26'b0, hw_int}, 32'h3F);
        cfg_addr = ADDR_STATUS;
        #1 chk("lvl.status", cfg_rdata, 32'h0);

        // edge mode on source 0: 3-cycle pulse becomes sticky
        irq_in = 6'h00;
        repeat (3) cycle("idle");
        cfg_we = 1; cfg_addr = ADDR_MODE; cfg_wdata = 32'h1;
        cycle("mode_wr");
        cfg_we = 0;
        irq_in = 6'h01;
        repeat (3) cycle("edge");
        chk("edge.rise", {26'b0, hw_int}, 32'h01);
        irq_in = 6'h00;
        repeat (3) cycle("edge_hold");
        chk("edge.sticky", {26'b0, hw_int}, 32'h01);
        cfg_we = 1; cfg_addr = ADDR_PEND; cfg_wdata = 32'h1;
        cycle("w1c");
        cfg_we = 0;
        chk("w1c.clear", {26'b0, hw_int}, 32'h00);

        // W1C coinciding with the edge-set: set wins
        irq_in = 6'h01;
        cycle("race");
        cycle("race");
        cfg_we = 1; cfg_addr = ADDR_PEND; cfg_wdata = 32'h1;
        cycle("race_w1c");
        cfg_we = 0; cfg_addr = ADDR_PEND;
        #1 chk("race.pend", cfg_rdata, 32'h1);
        irq_in = 6'h00;
        cfg_we = 1; cfg_wdata = 32'h1;
        cycle("race_clr");
        cfg_we = 0;

        // cp0_req redirect held off by fetch for 4 cycles
        cp0_req = 1;
        #1 chk("req.flush", {31'b0, flush}, 32'h1);
        cycle("req");
        cp0_req = 0;
        for (int i = 0; i < 4; i++) begin
            chk("req.valid", {31'b0, redir_valid}, 32'h1);
            chk("req.pc", redir_pc, 32'h4180);
            cycle("req_wait");
        end
        redir_ready = 1;
        chk("req.valid5", {31'b0, redir_valid}, 32'h1);
        cycle("req_acc");
        redir_ready = 0; cfg_addr = ADDR_STATUS;
        #1 chk("req.idle", cfg_rdata, 32'h0);

        // eret to EPC
        eret = 1; epc = 32'h3010;
        #1 chk("eret.flush", {31'b0, flush}, 32'h1);
        chk("eret.exl", {31'b0, exl_clr}, 32'h1);
        cycle("eret");
        eret = 0;
        chk("eret.pc", redir_pc, 32'h3010);
        chk("eret.exl_off", {31'b0, exl_clr}, 32'h0);
        redir_ready = 1;
        cycle("eret_acc");
        redir_ready = 0;

        // simultaneous eret and cp0_req
        eret = 1; cp0_req = 1;
        #1 chk("both.exl", {31'b0, exl_clr}, 32'h0);
        chk("both.flush", {31'b0, flush}, 32'h1);
        cycle("both");
        eret = 0; cp0_req = 0;
        chk("both.pc", redir_pc, 32'h4180);
        redir_ready = 1;
        cycle("both_acc");

        // randomized traffic
        for (int i = 0; i < 400; i++) begin
            if ($urandom_range(0, 2) == 0) irq_in = 6'($urandom);
            cp0_req     = ($urandom_range(0, 7) == 0);
            eret        = ($urandom_range(0, 7) == 0);
            epc         = $urandom;
            redir_ready = 1'($urandom_range(0, 1));
            cfg_we      = ($urandom_range(0, 3) == 0);
            cfg_addr    = 2'($urandom_range(0, 3));
            cfg_wdata   = $urandom;
            cycle("rnd");
        end

        // reset during REDIRECT
        cp0_req = 0; eret = 0; cfg_we = 0; redir_ready = 1;
        cycle("drain");
        cycle("drain");
        redir_ready = 0; cp0_req = 1;
        cycle("mid");
        cp0_req = 0;
        chk("mid.valid", {31'b0, redir_valid}, 32'h1);
        reset = 1'b0;
        #1 chk("mid.async", {31'b0, redir_valid}, 32'h0);
        model_reset();
        check_all("mid_rst");
        @(posedge clk);
        #1 reset = 1'b1;
        cfg_addr = ADDR_STATUS;
        #1 chk("post.status", cfg_rdata, 32'h0);
        cfg_addr = ADDR_MODE;
        #1 chk("post.mode", cfg_rdata, 32'h0);
        cfg_addr = ADDR_PEND;
        #1 chk("post.pend", cfg_rdata, 32'h0);
        repeat (3) cycle("post");

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
